// File: rtl/instr_fetch_queue.sv
// Instruction-fetch front end: issues one word read at a time to instruction
// memory and buffers returned instructions with their PCs for the decoder.
module instr_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]                        r_state;
  logic [ADDR_W-1:0]                 r_fetch_pc;
  logic                              r_mem_req;
  logic [ADDR_W-1:0]                 r_mem_addr;
  logic [PW:0]                       r_count;
  logic [PW-1:0]                     r_wptr;
  logic [PW-1:0]                     r_rptr;
  logic [DEPTH-1:0][DATA_W-1:0]      r_data;
  logic [DEPTH-1:0][ADDR_W-1:0]      r_pc;

  logic              w_busy;
  logic              w_space;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_redir_pc;

  assign w_busy     = (r_state != S_IDLE);
  // The outstanding read reserves a slot so a full FIFO never sees a push.
  assign w_space    = ({1'b0, r_count} + (PW+2)'(w_busy)) < (PW+2)'(DEPTH);
  assign w_redir_pc = redirect_pc & ~ADDR_W'(3);
  assign w_push     = (r_state == S_WAIT) && mem_ack && !redirect_valid;
  assign w_pop      = instr_valid && instr_ready && !redirect_valid;

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr_valid = (r_count != '0);
  assign instr_data  = r_data[r_rptr];
  assign instr_pc    = r_pc[r_rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_space && !redirect_valid) begin
            r_state    <= S_WAIT;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
            if (!redirect_valid) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
          end else if (redirect_valid) begin
            r_state <= S_DROP;
          end
        end
        S_DROP: begin
          // Request stays up on the old address; its data is thrown away.
          if (mem_ack) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
      if (redirect_valid) r_fetch_pc <= w_redir_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_data  <= '0;
      r_pc    <= '0;
    end else if (redirect_valid) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wptr] <= mem_rdata;
        r_pc[r_wptr]   <= r_mem_addr;
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized and directed bench for instr_fetch_queue; a transaction-level
// model predicts requests and FIFO contents, a negedge monitor checks them.
module tb_instr_fetch_queue;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          instr_valid;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          instr_ready = 1'b0;

  instr_fetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  int total = 0;
  int bad = 0;

  // reference model state
  ent_t        exp_q[$];
  bit          m_out = 1'b0;
  bit          m_stale = 1'b0;
  logic [31:0] m_req_addr = '0;
  logic [31:0] m_next_pc = '0;
  bit          pop_seen = 1'b0;
  bit          mon_en = 1'b0;
  bit          prev_req = 1'b0;
  logic [31:0] issued[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_issued(input int idx, input logic [31:0] exp);
    logic [31:0] v;
    v = (idx < issued.size()) ? issued[idx] : 32'hxxxxxxxx;
    chk($sformatf("issued[%0d]", idx), v, exp);
  endtask

  // Advance the model by one clock edge given the inputs applied at it.
  task automatic model_update(input bit rv, input logic [31:0] rpc, input bit ack);
    int occ;
    ent_t e;
    occ = exp_q.size() + (pop_seen ? 1 : 0);
    pop_seen = 1'b0;
    if (m_out) begin
      if (ack) begin
        m_out = 1'b0;
        if (!rv && !m_stale) begin
          e.pc = m_req_addr;
          e.data = mem_word(m_req_addr);
          exp_q.push_back(e);
          m_next_pc = m_next_pc + 32'd4;
        end
        m_stale = 1'b0;
      end else if (rv) begin
        m_stale = 1'b1;
      end
    end else if (!rv && occ < DEPTH) begin
      m_out = 1'b1;
      m_req_addr = m_next_pc;
    end
    if (rv) begin
      exp_q.delete();
      m_next_pc = {rpc[31:2], 2'b00};
    end
  endtask

  // Called just after a rising edge; drives inputs for the next edge.
  task automatic cyc(input bit rv, input logic [31:0] rpc, input bit ack_in, input bit rdy);
    bit ack;
    ack = ack_in && m_out;
    redirect_valid = rv;
    redirect_pc = rpc;
    mem_ack = ack;
    mem_rdata = ack ? mem_word(m_req_addr) : $urandom;
    instr_ready = rdy;
    @(posedge clk);
    #1;
    model_update(rv, rpc, ack);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mem_req", mem_req, m_out);
      if (m_out) chk("mem_addr", mem_addr, m_req_addr);
      chk("instr_valid", instr_valid, exp_q.size() != 0);
      if (mem_req && !prev_req) issued.push_back(mem_addr);
      prev_req = mem_req;
      if (instr_valid && exp_q.size() > 0) begin
        chk("instr_pc", instr_pc, exp_q[0].pc);
        chk("instr_data", instr_data, exp_q[0].data);
        if (instr_ready && !redirect_valid) begin
          void'(exp_q.pop_front());
          pop_seen = 1'b1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_instr_valid"}, instr_valid, 0);
    chk({tag, "_instr_data"}, instr_data, 0);
    chk({tag, "_instr_pc"}, instr_pc, 0);
  endtask

  initial begin
    int n;
    bit rv;
    logic [31:0] tgt;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    reset = 1'b1;
    prev_req = 1'b0;
    mon_en = 1'b1;

    // Sequential fetch, immediate acks, decoder always ready
    repeat (12) cyc(0, 0, 1, 1);
    chk_issued(0, 32'h0);
    chk_issued(1, 32'h4);
    chk_issued(2, 32'h8);
    chk_issued(3, 32'hC);

    // Fill with decoder stalled: exactly DEPTH requests, then stop
    cyc(1, 32'h0, 1, 0);
    issued.delete();
    repeat (20) cyc(0, 0, 1, 0);
    chk("full_req_count", issued.size(), 4);
    chk_issued(3, 32'hC);
    chk("full_mem_req", mem_req, 0);
    cyc(0, 0, 1, 1);
    issued.delete();
    repeat (6) cyc(0, 0, 1, 0);
    chk("resume_count", issued.size(), 1);
    chk_issued(0, 32'h10);

    // Redirect while the read of 0x8 is outstanding, ack 3 cycles late
    cyc(1, 32'h0, 1, 1);
    n = 0;
    while (!(m_out && m_req_addr == 32'h8) && n < 50) begin
      cyc(0, 0, 1, 1);
      n++;
    end
    chk("reach_req8", n < 50, 1);
    cyc(1, 32'h103, 0, 1);
    issued.delete();
    chk("flush_valid", instr_valid, 0);
    repeat (2) cyc(0, 0, 0, 1);
    chk("drop_hold_req", mem_req, 1);
    chk("drop_hold_addr", mem_addr, 32'h8);
    repeat (5) cyc(0, 0, 1, 1);
    chk_issued(0, 32'h100);

    // Redirect coinciding with ack and pop while two entries are queued
    cyc(1, 32'h0, 1, 0);
    n = 0;
    while (!(m_out && exp_q.size() == 2) && n < 50) begin
      cyc(0, 0, 1, 0);
      n++;
    end
    chk("reach_two", n < 50, 1);
    cyc(1, 32'h200, 1, 1);
    issued.delete();
    chk("redir_ack_valid", instr_valid, 0);
    chk("redir_ack_req", mem_req, 0);
    repeat (4) cyc(0, 0, 1, 1);
    chk_issued(0, 32'h200);

    // PC wrap at the top of the address space
    cyc(1, 32'hFFFFFFF8, 1, 1);
    issued.delete();
    repeat (8) cyc(0, 0, 1, 1);
    chk_issued(0, 32'hFFFFFFF8);
    chk_issued(1, 32'hFFFFFFFC);
    chk_issued(2, 32'h00000000);

    // Reset in the middle of a read, late ack ignored
    n = 0;
    while (!m_out && n < 20) begin
      cyc(0, 0, 0, 1);
      n++;
    end
    chk("reach_wait", m_out, 1);
    mon_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    mem_ack = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    chk("late_ack_valid", instr_valid, 0);
    chk("late_ack_req", mem_req, 0);
    exp_q.delete();
    m_out = 1'b0;
    m_stale = 1'b0;
    m_next_pc = '0;
    pop_seen = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    prev_req = 1'b0;
    issued.delete();
    mon_en = 1'b1;
    repeat (6) cyc(0, 0, 1, 1);
    chk_issued(0, 32'h0);
    chk_issued(1, 32'h4);

    // Random traffic
    repeat (3000) begin
      rv = ($urandom_range(99) < 4);
      tgt = ($urandom_range(3) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(15))) : $urandom;
      cyc(rv, tgt, $urandom_range(99) < 40, $urandom_range(99) < 60);
    end

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
